// File: rtl/axil_master_arbiter.sv
// -----------------------------------------------------------------------------
// axil_master_arbiter
//   Shares one AXI4-Lite master port between two local requesters. Arbitration
//   is round-robin with a single outstanding transaction. The block sequences
//   AW/W/B for writes and AR/R for reads and hands the response back to the
//   requester that was granted.
//
// Ports
//   M_AXI_ACLK / M_AXI_ARESET : clock, synchronous active-high reset
//   REQ_VALID/WE/ADDR/WDATA   : per-requester command (requester i in slice i)
//   REQ_READY                 : one-cycle accept pulse to the granted requester
//   RSP_VALID/RDATA/RESP      : one-cycle completion pulse plus held result
//   M_AXI_*                   : AXI4-Lite master channels (AW, W, B, AR, R)
// -----------------------------------------------------------------------------
module axil_master_arbiter #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 4
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic [1:0]                      REQ_VALID,
  input  logic [1:0]                      REQ_WE,
  input  logic [2*C_M_AXI_ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [2*C_M_AXI_DATA_WIDTH-1:0] REQ_WDATA,
  output logic [1:0]                      REQ_READY,
  output logic [1:0]                      RSP_VALID,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   RSP_RDATA,
  output logic [1:0]                      RSP_RESP,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  output logic [2:0]                      M_AXI_ARPROT,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_WR_ADDR_DATA = 3'd1,
    S_WR_RESP      = 3'd2,
    S_RD_ADDR      = 3'd3,
    S_RD_DATA      = 3'd4,
    S_RESPOND      = 3'd5
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_last_grant, w_last_grant_nxt;
  logic          r_grant, w_grant_nxt;
  logic [1:0]    r_req_ready, w_req_ready_nxt;
  logic [1:0]    r_rsp_valid, w_rsp_valid_nxt;
  logic [AW-1:0] r_awaddr, w_awaddr_nxt;
  logic          r_awvalid, w_awvalid_nxt;
  logic [DW-1:0] r_wdata, w_wdata_nxt;
  logic          r_wvalid, w_wvalid_nxt;
  logic          r_bready, w_bready_nxt;
  logic [AW-1:0] r_araddr, w_araddr_nxt;
  logic          r_arvalid, w_arvalid_nxt;
  logic          r_rready, w_rready_nxt;
  logic [DW-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic [1:0]    r_rsp_resp, w_rsp_resp_nxt;

  // Arbitration: a lone requester wins outright; on contention the one that
  // did not complete last wins.
  logic          w_grant;
  logic          w_req_we;
  logic [AW-1:0] w_req_addr;
  logic [DW-1:0] w_req_wdata;
  logic          w_aw_done;
  logic          w_w_done;

  assign w_grant     = (REQ_VALID == 2'b11) ? ~r_last_grant : REQ_VALID[1];
  assign w_req_we    = w_grant ? REQ_WE[1] : REQ_WE[0];
  assign w_req_addr  = w_grant ? REQ_ADDR[2*AW-1:AW] : REQ_ADDR[AW-1:0];
  assign w_req_wdata = w_grant ? REQ_WDATA[2*DW-1:DW] : REQ_WDATA[DW-1:0];

  // A channel counts as done once its VALID has already dropped or it
  // handshakes this cycle, so AW and W may complete in either order.
  assign w_aw_done = ~r_awvalid | M_AXI_AWREADY;
  assign w_w_done  = ~r_wvalid | M_AXI_WREADY;

  // Next-state and next-output computation for the transaction sequencer.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_grant_nxt      = r_grant;
    w_req_ready_nxt  = 2'b00;
    w_rsp_valid_nxt  = 2'b00;
    w_awaddr_nxt     = r_awaddr;
    w_awvalid_nxt    = r_awvalid;
    w_wdata_nxt      = r_wdata;
    w_wvalid_nxt     = r_wvalid;
    w_bready_nxt     = r_bready;
    w_araddr_nxt     = r_araddr;
    w_arvalid_nxt    = r_arvalid;
    w_rready_nxt     = r_rready;
    w_rsp_rdata_nxt  = r_rsp_rdata;
    w_rsp_resp_nxt   = r_rsp_resp;
    case (r_state)
      S_IDLE: begin
        if (REQ_VALID != 2'b00) begin
          w_grant_nxt     = w_grant;
          w_req_ready_nxt = w_grant ? 2'b10 : 2'b01;
          if (w_req_we) begin
            w_awaddr_nxt  = w_req_addr;
            w_wdata_nxt   = w_req_wdata;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
            w_state_nxt   = S_WR_ADDR_DATA;
          end else begin
            w_araddr_nxt  = w_req_addr;
            w_arvalid_nxt = 1'b1;
            w_state_nxt   = S_RD_ADDR;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WR_ADDR_DATA: begin
        if (M_AXI_AWREADY) begin
          w_awvalid_nxt = 1'b0;
        end else begin
          w_awvalid_nxt = r_awvalid;
        end
        if (M_AXI_WREADY) begin
          w_wvalid_nxt = 1'b0;
        end else begin
          w_wvalid_nxt = r_wvalid;
        end
        if (w_aw_done && w_w_done) begin
          w_bready_nxt = 1'b1;
          w_state_nxt  = S_WR_RESP;
        end else begin
          w_state_nxt = S_WR_ADDR_DATA;
        end
      end
      S_WR_RESP: begin
        if (M_AXI_BVALID) begin
          w_bready_nxt    = 1'b0;
          w_rsp_resp_nxt  = M_AXI_BRESP;
          w_rsp_rdata_nxt = {DW{1'b0}};
          w_state_nxt     = S_RESPOND;
        end else begin
          w_state_nxt = S_WR_RESP;
        end
      end
      S_RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = S_RD_DATA;
        end else begin
          w_state_nxt = S_RD_ADDR;
        end
      end
      S_RD_DATA: begin
        if (M_AXI_RVALID) begin
          w_rready_nxt    = 1'b0;
          w_rsp_rdata_nxt = M_AXI_RDATA;
          w_rsp_resp_nxt  = M_AXI_RRESP;
          w_state_nxt     = S_RESPOND;
        end else begin
          w_state_nxt = S_RD_DATA;
        end
      end
      S_RESPOND: begin
        w_rsp_valid_nxt  = r_grant ? 2'b10 : 2'b01;
        w_last_grant_nxt = r_grant;
        w_state_nxt      = S_IDLE;
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_awvalid_nxt = 1'b0;
        w_wvalid_nxt  = 1'b0;
        w_bready_nxt  = 1'b0;
        w_arvalid_nxt = 1'b0;
        w_rready_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops every handshake and discards
  // any command in flight.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_req_ready  <= 2'b00;
      r_rsp_valid  <= 2'b00;
      r_awaddr     <= {AW{1'b0}};
      r_awvalid    <= 1'b0;
      r_wdata      <= {DW{1'b0}};
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_araddr     <= {AW{1'b0}};
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_rsp_rdata  <= {DW{1'b0}};
      r_rsp_resp   <= 2'b00;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_grant      <= w_grant_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_awaddr     <= w_awaddr_nxt;
      r_awvalid    <= w_awvalid_nxt;
      r_wdata      <= w_wdata_nxt;
      r_wvalid     <= w_wvalid_nxt;
      r_bready     <= w_bready_nxt;
      r_araddr     <= w_araddr_nxt;
      r_arvalid    <= w_arvalid_nxt;
      r_rready     <= w_rready_nxt;
      r_rsp_rdata  <= w_rsp_rdata_nxt;
      r_rsp_resp   <= w_rsp_resp_nxt;
    end
  end

  assign REQ_READY     = r_req_ready;
  assign RSP_VALID     = r_rsp_valid;
  assign RSP_RDATA     = r_rsp_rdata;
  assign RSP_RESP      = r_rsp_resp;
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_WSTRB   = {(DW/8){1'b1}};
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_RREADY  = r_rready;

endmodule
